// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - EX/MEM-side inputs and MEM/WB-side outputs of the memory stage
//
// Bundles every non-clock, non-reset signal of mem_wb_stage.
//   master : upstream pipeline / environment (drives EX_MEM_*, optional stall)
//   slave  : mem_wb_stage itself (drives mem_fwd_* and MEM_WB_*)
// Optional feature macro: MEM_WB_STALL_EN adds the stall signal.
interface mem_wb_stage_if;
    logic [7:0]  EX_MEM_alu_out;
    logic [7:0]  EX_MEM_B;
    logic [7:0]  EX_MEM_shift_out;
    logic        EX_MEM_mem_write;
    logic        EX_MEM_reg_write;
    logic [18:0] EX_MEM_instruction;
    logic [1:0]  EX_MEM_reg_write_mux;
`ifdef MEM_WB_STALL_EN
    logic        stall;
`endif
    logic [7:0]  mem_fwd_data;
    logic [2:0]  mem_fwd_rd;
    logic        mem_fwd_valid;
    logic [7:0]  MEM_WB_data;
    logic [2:0]  MEM_WB_rd;
    logic        MEM_WB_reg_write;
    logic [18:0] MEM_WB_instruction;

    modport master (
        output EX_MEM_alu_out, EX_MEM_B, EX_MEM_shift_out, EX_MEM_mem_write,
               EX_MEM_reg_write, EX_MEM_instruction, EX_MEM_reg_write_mux,
`ifdef MEM_WB_STALL_EN
        output stall,
`endif
        input  mem_fwd_data, mem_fwd_rd, mem_fwd_valid,
               MEM_WB_data, MEM_WB_rd, MEM_WB_reg_write, MEM_WB_instruction
    );

    modport slave (
        input  EX_MEM_alu_out, EX_MEM_B, EX_MEM_shift_out, EX_MEM_mem_write,
               EX_MEM_reg_write, EX_MEM_instruction, EX_MEM_reg_write_mux,
`ifdef MEM_WB_STALL_EN
        input  stall,
`endif
        output mem_fwd_data, mem_fwd_rd, mem_fwd_valid,
               MEM_WB_data, MEM_WB_rd, MEM_WB_reg_write, MEM_WB_instruction
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage: data memory, write-back select, MEM/WB register
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; clears MEM/WB register and all memory
//   bus   : mem_wb_stage_if.slave
//           in : EX_MEM_alu_out (result / address), EX_MEM_B (store data),
//                EX_MEM_shift_out, EX_MEM_mem_write, EX_MEM_reg_write,
//                EX_MEM_instruction, EX_MEM_reg_write_mux, [stall]
//           out: mem_fwd_data/rd/valid (combinational, for forwarding),
//                MEM_WB_data/rd/reg_write/instruction (registered)
// Parameters: DMEM_DEPTH (memory entries), RD_MSB (top bit of 3-bit rd field)
// Optional feature macro: MEM_WB_STALL_EN (stall holds MEM/WB and blocks stores).
module mem_wb_stage #(
    parameter int DMEM_DEPTH = 256,
    parameter int RD_MSB     = 13
) (
    input  logic           clk,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);
    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [7:0]    r_dmem [DMEM_DEPTH];
    logic [7:0]    r_wb_data;
    logic [2:0]    r_wb_rd;
    logic          r_wb_reg_write;
    logic [18:0]   r_wb_instruction;

    logic [AW-1:0] w_addr;
    logic [7:0]    w_rdata;
    logic [7:0]    w_wb_value;
    logic [2:0]    w_rd;
    logic          w_capture;
    logic          w_store;

    // Modulo keeps non-power-of-two depths addressable without aliasing out of range.
    assign w_addr = AW'({24'd0, bus.EX_MEM_alu_out} % 32'(DMEM_DEPTH));

    // Asynchronous read: a same-cycle store is not yet written, so old data is returned.
    assign w_rdata = r_dmem[w_addr];
    assign w_rd    = bus.EX_MEM_instruction[RD_MSB -: 3];

`ifdef MEM_WB_STALL_EN
    assign w_capture = ~bus.stall;
`else
    assign w_capture = 1'b1;
`endif
    assign w_store = bus.EX_MEM_mem_write & w_capture;

    always_comb begin
        w_wb_value = bus.EX_MEM_alu_out;
        unique case (bus.EX_MEM_reg_write_mux)
            2'b00: w_wb_value = bus.EX_MEM_alu_out;
            2'b01: w_wb_value = w_rdata;
            2'b10: w_wb_value = bus.EX_MEM_shift_out;
            2'b11: w_wb_value = bus.EX_MEM_instruction[7:0];
            default: w_wb_value = bus.EX_MEM_alu_out;
        endcase
    end

    assign bus.mem_fwd_data  = w_wb_value;
    assign bus.mem_fwd_rd    = w_rd;
    assign bus.mem_fwd_valid = bus.EX_MEM_reg_write;

    // Whole memory is cleared by reset, so a store racing a reset is simply lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                r_dmem[i] <= 8'h00;
            end
        end else if (w_store) begin
            r_dmem[w_addr] <= bus.EX_MEM_B;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_data        <= 8'h00;
            r_wb_rd          <= 3'd0;
            r_wb_reg_write   <= 1'b0;
            r_wb_instruction <= 19'd0;
        end else if (w_capture) begin
            r_wb_data        <= w_wb_value;
            r_wb_rd          <= w_rd;
            r_wb_reg_write   <= bus.EX_MEM_reg_write;
            r_wb_instruction <= bus.EX_MEM_instruction;
        end
    end

    assign bus.MEM_WB_data        = r_wb_data;
    assign bus.MEM_WB_rd          = r_wb_rd;
    assign bus.MEM_WB_reg_write   = r_wb_reg_write;
    assign bus.MEM_WB_instruction = r_wb_instruction;
endmodule
